eprom_prog_sequencer: RTL

//  Byte-program/verify sequencer for 27xx-class EPROMs (M2764A "intelligent programming" algorithm).

---
 rtl/eprom_prog_pkg.sv | 26 ++
 rtl/eprom_delay_timer.sv | 32 +++
 rtl/eprom_prog_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/eprom_prog_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eprom_prog_pkg
//  Purpose  : Shared types and constants for the EPROM program/verify sequencer
//  Revision : 1.0 - initial release
// ============================================================================
package eprom_prog_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        PULSE    = 3'd2,
        RECOVER  = 3'd3,
        VERIFY   = 3'd4,
        OVERPROG = 3'd5,
        FINISH   = 3'd6
    } state_t;

    // EPROM control pins are active-low
    localparam logic       PIN_ASSERT    = 1'b0;
    localparam logic       PIN_DEASSERT  = 1'b1;
    localparam logic [7:0] PROG_CMD_BYTE = 8'd2;
    localparam int         TIMER_W       = 24;

endpackage
`default_nettype wire

// File: rtl/eprom_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module   : eprom_delay_timer
//  Purpose  : Loadable down-counter with zero flag, shared by all timed states
//  Revision : 1.0 - initial release
// ============================================================================
module eprom_delay_timer #(
    parameter int WIDTH = 24
) (
    input  logic             osc,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/eprom_prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : eprom_prog_sequencer
//  Purpose  : M2764A-style byte program/verify sequencer driving the ZIF pins.
//             Define EPROM_SEQ_OVERPROG_EN to add the final overprogram pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module eprom_prog_sequencer
    import eprom_prog_pkg::*;
#(
    parameter int ADDR_W        = 13,
    parameter int DATA_W        = 8,
    parameter int TICKS_PER_MS  = 12000,
    parameter int MAX_PULSES    = 25,
    parameter int OVERPROG_MULT = 3,
    parameter int SETTLE_TICKS  = 24
) (
    input  logic              osc,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [7:0]        pulse_cnt,
    output logic [ADDR_W-1:0] dut_addr,
    output logic [DATA_W-1:0] dut_dout,
    output logic              dut_doe,
    input  logic [DATA_W-1:0] dut_din,
    output logic              dut_E,
    output logic              dut_G,
    output logic              dut_P
);

    localparam logic [TIMER_W-1:0] C_SETTLE_LOAD = TIMER_W'(SETTLE_TICKS - 1);
    localparam logic [TIMER_W-1:0] C_PULSE_LOAD  = TIMER_W'(TICKS_PER_MS - 1);

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [7:0]          r_pulse_cnt;
    logic                r_fail, r_busy, r_done, r_doe, r_E, r_G, r_P;
    logic                w_load, w_latch, w_pulse_inc, w_set_fail, w_zero;
    logic [TIMER_W-1:0]  w_load_val;

`ifdef EPROM_SEQ_OVERPROG_EN
    logic                r_passed;
    logic                w_set_pass;
    logic [15:0]         w_op_ms;
    logic [TIMER_W-1:0]  w_op_ticks;

    assign w_op_ms    = 16'(OVERPROG_MULT) * {8'd0, r_pulse_cnt};
    assign w_op_ticks = TIMER_W'(w_op_ms) * TIMER_W'(TICKS_PER_MS);
`endif

    eprom_delay_timer #(.WIDTH(TIMER_W)) u_timer (
        .osc      (osc),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_val  = C_SETTLE_LOAD;
        w_latch     = 1'b0;
        w_pulse_inc = 1'b0;
        w_set_fail  = 1'b0;
`ifdef EPROM_SEQ_OVERPROG_EN
        w_set_pass  = 1'b0;
`endif
        if (r_state != IDLE && r_state != FINISH && abort) begin
            w_next     = FINISH;
            w_set_fail = 1'b1;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    w_next  = SETUP;
                    w_load  = 1'b1;
                    w_latch = 1'b1;
                end
                SETUP: if (w_zero) begin
                    w_load = 1'b1;
`ifdef EPROM_SEQ_OVERPROG_EN
                    if (r_passed) begin
                        w_next     = OVERPROG;
                        w_load_val = w_op_ticks - 1'b1;
                    end else
`endif
                    begin
                        w_next      = PULSE;
                        w_load_val  = C_PULSE_LOAD;
                        w_pulse_inc = 1'b1;
                    end
                end
                PULSE: if (w_zero) begin
                    w_next = RECOVER;
                    w_load = 1'b1;
                end
                RECOVER: if (w_zero) begin
                    w_load = 1'b1;
                    w_next = VERIFY;
`ifdef EPROM_SEQ_OVERPROG_EN
                    if (r_passed) w_next = FINISH;
`endif
                end
                VERIFY: if (w_zero) begin
                    if (dut_din == r_data) begin
`ifdef EPROM_SEQ_OVERPROG_EN
                        w_next     = SETUP;
                        w_load     = 1'b1;
                        w_set_pass = 1'b1;
`else
                        w_next     = FINISH;
`endif
                    end else if (r_pulse_cnt < 8'(MAX_PULSES)) begin
                        w_next = SETUP;
                        w_load = 1'b1;
                    end else begin
                        w_next     = FINISH;
                        w_set_fail = 1'b1;
                    end
                end
`ifdef EPROM_SEQ_OVERPROG_EN
                OVERPROG: if (w_zero) begin
                    w_next = RECOVER;
                    w_load = 1'b1;
                end
`endif
                FINISH:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Pin levels are registered from the next state so they change glitch-free on the edge
    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_pulse_cnt <= '0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_doe       <= 1'b0;
            r_E         <= PIN_DEASSERT;
            r_G         <= PIN_DEASSERT;
            r_P         <= PIN_DEASSERT;
`ifdef EPROM_SEQ_OVERPROG_EN
            r_passed    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_addr      <= cmd_addr;
                r_data      <= cmd_data;
                r_pulse_cnt <= '0;
                r_fail      <= 1'b0;
`ifdef EPROM_SEQ_OVERPROG_EN
                r_passed    <= 1'b0;
`endif
            end
            if (w_pulse_inc && r_pulse_cnt != 8'hFF) r_pulse_cnt <= r_pulse_cnt + 8'd1;
            if (w_set_fail) r_fail <= 1'b1;
`ifdef EPROM_SEQ_OVERPROG_EN
            if (w_set_pass) r_passed <= 1'b1;
`endif
            r_busy <= (w_next != IDLE) && (w_next != FINISH);
            r_done <= (w_next == FINISH);
            r_doe  <= (w_next == SETUP) || (w_next == PULSE) ||
                      (w_next == RECOVER) || (w_next == OVERPROG);
            r_E    <= (w_next == IDLE || w_next == FINISH) ? PIN_DEASSERT : PIN_ASSERT;
            r_G    <= (w_next == VERIFY) ? PIN_ASSERT : PIN_DEASSERT;
            r_P    <= (w_next == PULSE || w_next == OVERPROG) ? PIN_ASSERT : PIN_DEASSERT;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign fail      = r_fail;
    assign pulse_cnt = r_pulse_cnt;
    assign dut_addr  = r_addr;
    assign dut_dout  = r_data;
    assign dut_doe   = r_doe;
    assign dut_E     = r_E;
    assign dut_G     = r_G;
    assign dut_P     = r_P;

endmodule
`default_nettype wire
